// File: rtl/alu_ascii_pkg.sv
// ============================================================================
// alu_ascii_pkg : ASCII characters, ALU opcodes, parser states, error codes
// Revision      : 1.0
// ============================================================================
`default_nettype none

package alu_ascii_pkg;

  localparam logic [7:0] c_ascii_0      = 8'h30;
  localparam logic [7:0] c_ascii_9      = 8'h39;
  localparam logic [7:0] c_ascii_a_lc   = 8'h61;
  localparam logic [7:0] c_ascii_f_lc   = 8'h66;
  localparam logic [7:0] c_ascii_plus   = 8'h2B;
  localparam logic [7:0] c_ascii_minus  = 8'h2D;
  localparam logic [7:0] c_ascii_and    = 8'h41;
  localparam logic [7:0] c_ascii_or     = 8'h4F;
  localparam logic [7:0] c_ascii_xor    = 8'h58;
  localparam logic [7:0] c_ascii_nand   = 8'h4E;
  localparam logic [7:0] c_ascii_gt     = 8'h3E;
  localparam logic [7:0] c_ascii_slash  = 8'h2F;
  localparam logic [7:0] c_ascii_cr     = 8'h0D;
  localparam logic [7:0] c_ascii_equal  = 8'h3D;
  localparam logic [7:0] c_ascii_space  = 8'h20;
  localparam logic [7:0] c_ascii_dollar = 8'h24;

  localparam logic [7:0] c_opc_add  = 8'h20;
  localparam logic [7:0] c_opc_sub  = 8'h22;
  localparam logic [7:0] c_opc_and  = 8'h24;
  localparam logic [7:0] c_opc_or   = 8'h25;
  localparam logic [7:0] c_opc_xor  = 8'h26;
  localparam logic [7:0] c_opc_nand = 8'h27;
  localparam logic [7:0] c_opc_gt   = 8'h03;
  localparam logic [7:0] c_opc_div  = 8'h02;
  localparam logic [7:0] c_opc_none = 8'hFF;

  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_bad_char = 2'd1;
  localparam logic [1:0] c_err_count    = 2'd2;
  localparam logic [1:0] c_err_overrun  = 2'd3;

  typedef enum logic [1:0] {
    ST_OPA  = 2'd0,
    ST_OPB  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } parse_state_e;

  function automatic logic is_dec_digit(input logic [7:0] ch);
    return (ch >= c_ascii_0) && (ch <= c_ascii_9);
  endfunction

  function automatic logic is_terminator(input logic [7:0] ch);
    return (ch == c_ascii_cr) || (ch == c_ascii_equal);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_op_decode.sv
// ============================================================================
// ascii_op_decode : combinational ASCII operator character -> ALU opcode
// Revision        : 1.0
// ============================================================================
`default_nettype none

module ascii_op_decode
  import alu_ascii_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_op,
  output logic [7:0] o_opcode
);

  always_comb begin
    o_is_op  = 1'b1;
    o_opcode = c_opc_none;
    case (i_char)
      c_ascii_plus:  o_opcode = c_opc_add;
      c_ascii_minus: o_opcode = c_opc_sub;
      c_ascii_and:   o_opcode = c_opc_and;
      c_ascii_or:    o_opcode = c_opc_or;
      c_ascii_xor:   o_opcode = c_opc_xor;
      c_ascii_nand:  o_opcode = c_opc_nand;
      c_ascii_gt:    o_opcode = c_opc_gt;
      c_ascii_slash: o_opcode = c_opc_div;
      default:       o_is_op  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ascii_cmd_parser.sv
// ============================================================================
// ascii_cmd_parser : "<A><op><B><term>" line parser feeding the ALU handshake
// Build option     : PARSE_HEX_EN enables '$'-prefixed lowercase hex operands
// Revision         : 1.0
// ============================================================================
`default_nettype none

module ascii_cmd_parser
  import alu_ascii_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [7:0]        opcode,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int                c_cnt_w   = $clog2(MAX_DIGITS + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_DIGITS);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  parse_state_e        state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [7:0]          opcode_q, opcode_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                w_is_space;
  logic                w_is_term;
  logic                w_is_dec;
  logic                w_is_digit;
  logic                w_is_op;
  logic [7:0]          w_op_code;
  logic [3:0]          w_nib;
  logic [DATA_W-1:0]   w_nib_ext;
  logic [DATA_W-1:0]   w_acc_next;

  ascii_op_decode u_op_decode (
    .i_char   (rx_data),
    .o_is_op  (w_is_op),
    .o_opcode (w_op_code)
  );

  assign w_is_space = (rx_data == c_ascii_space);
  assign w_is_term  = is_terminator(rx_data);
  assign w_is_dec   = is_dec_digit(rx_data);
  assign w_nib_ext  = {{(DATA_W-4){1'b0}}, w_nib};

`ifdef PARSE_HEX_EN
  logic hex_q, hex_d;
  logic w_is_hex_lc;
  logic w_is_dollar;

  assign w_is_hex_lc = (rx_data >= c_ascii_a_lc) && (rx_data <= c_ascii_f_lc);
  assign w_is_dollar = (rx_data == c_ascii_dollar);
  // Uppercase letters stay operators, so only lowercase a-f extend the digit set
  assign w_is_digit  = w_is_dec || (hex_q && w_is_hex_lc);
  assign w_nib       = w_is_dec ? rx_data[3:0] : rx_data[3:0] + 4'd9;
  assign w_acc_next  = hex_q ? ((acc_q << 4) | w_nib_ext)
                             : ((acc_q << 3) + (acc_q << 1) + w_nib_ext);
`else
  assign w_is_digit  = w_is_dec;
  assign w_nib       = rx_data[3:0];
  assign w_acc_next  = (acc_q << 3) + (acc_q << 1) + w_nib_ext;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    cmd_valid_d = cmd_valid_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef PARSE_HEX_EN
    hex_d       = hex_q;
`endif

    case (state_q)
      ST_OPA, ST_OPB: begin
        if (rx_valid && !w_is_space) begin
          if (w_is_digit) begin
            if (cnt_q == c_max_cnt) begin
              err_valid_d = 1'b1;
              err_code_d  = c_err_count;
              state_d     = ST_ERR;
            end else begin
              acc_d = w_acc_next;
              cnt_d = cnt_q + c_cnt_one;
            end
          end
`ifdef PARSE_HEX_EN
          else if (w_is_dollar) begin
            if ((cnt_q == '0) && !hex_q) begin
              hex_d = 1'b1;
            end else begin
              err_valid_d = 1'b1;
              err_code_d  = c_err_bad_char;
              state_d     = ST_ERR;
            end
          end
`endif
          else if ((state_q == ST_OPA && w_is_op) || (state_q == ST_OPB && w_is_term)) begin
            if (cnt_q == '0) begin
              err_valid_d = 1'b1;
              err_code_d  = c_err_count;
              state_d     = ST_ERR;
            end else if (state_q == ST_OPA) begin
              a_d      = acc_q;
              opcode_d = w_op_code;
              state_d  = ST_OPB;
            end else begin
              op_a_d      = a_q;
              op_b_d      = acc_q;
              cmd_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = c_err_bad_char;
            state_d     = ST_ERR;
          end
        end
      end
      ST_HOLD: begin
        // Bytes arriving while a command waits are lost; acceptance still proceeds
        if (rx_valid) begin
          err_valid_d = 1'b1;
          err_code_d  = c_err_overrun;
        end
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_OPA;
        end
      end
      ST_ERR: begin
        if (rx_valid && w_is_term) begin
          state_d = ST_OPA;
        end
      end
      default: state_d = ST_OPA;
    endcase

    // Every state change starts a fresh operand
    if (state_d != state_q) begin
      acc_d = '0;
      cnt_d = '0;
`ifdef PARSE_HEX_EN
      hex_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OPA;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= c_opc_none;
      cmd_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= c_err_none;
`ifdef PARSE_HEX_EN
      hex_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      cmd_valid_q <= cmd_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
`ifdef PARSE_HEX_EN
      hex_q       <= hex_d;
`endif
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign opcode    = opcode_q;
  assign cmd_valid = cmd_valid_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_ascii_cmd_parser.sv
// ============================================================================
// tb_ascii_cmd_parser : directed plus random line stimulus against a text model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_ascii_cmd_parser;

  localparam int DATA_W     = 8;
  localparam int MAX_DIGITS = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [7:0]        opcode;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              err_valid;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  ascii_cmd_parser #(.DATA_W(DATA_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .opcode    (opcode),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: the non-space text of the current line is kept and
  // re-parsed from scratch on every byte.
  byte unsigned      line[$];
  bit                m_hold;
  bit                m_err;
  logic [DATA_W-1:0] m_a, m_b;
  logic [7:0]        m_opc;
  int                last_err;

  function automatic int op_of(input byte unsigned c);
    case (c)
      "+": return 'h20;
      "-": return 'h22;
      "A": return 'h24;
      "O": return 'h25;
      "X": return 'h26;
      "N": return 'h27;
      ">": return 'h03;
      "/": return 'h02;
      default: return -1;
    endcase
  endfunction

  // st: 0 incomplete, 1 bad char, 2 digit count, 3 complete command
  function automatic void eval_line(output int st, output logic [DATA_W-1:0] a,
                                    output logic [DATA_W-1:0] b, output logic [7:0] opc);
    int phase = 0;
    int n = 0;
    int val = 0;
    int dv;
    bit hex = 0;
    byte unsigned c;
    st = 0; a = '0; b = '0; opc = '0;
    foreach (line[i]) begin
      c  = line[i];
      dv = -1;
      if (c >= "0" && c <= "9") dv = int'(c) - 48;
`ifdef PARSE_HEX_EN
      else if (hex && c >= "a" && c <= "f") dv = int'(c) - 87;
`endif
      if (dv >= 0) begin
        if (n == MAX_DIGITS) begin st = 2; return; end
        val = (val * (hex ? 16 : 10) + dv) % (1 << DATA_W);
        n++;
      end
`ifdef PARSE_HEX_EN
      else if (c == "$" && n == 0 && !hex) hex = 1;
`endif
      else if (phase == 0 && op_of(c) >= 0) begin
        if (n == 0) begin st = 2; return; end
        a = DATA_W'(val); opc = 8'(op_of(c));
        phase = 1; n = 0; val = 0; hex = 0;
      end else if (phase == 1 && (c == 8'd13 || c == "=")) begin
        if (n == 0) st = 2;
        else begin st = 3; b = DATA_W'(val); end
        return;
      end else begin
        st = 1; return;
      end
    end
  endfunction

  task automatic step(input bit v, input byte unsigned b, input bit rdy);
    int st;
    logic [DATA_W-1:0] ea, eb;
    logic [7:0] eo;
    bit exp_err = 0;
    int exp_code = 0;
    rx_valid = v; rx_data = b; cmd_ready = rdy;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (m_hold) begin
      if (v) begin exp_err = 1; exp_code = 3; end
      if (rdy) m_hold = 0;
    end else if (m_err) begin
      if (v && (b == 8'd13 || b == "=")) m_err = 0;
    end else if (v && b != " ") begin
      line.push_back(b);
      eval_line(st, ea, eb, eo);
      if (st == 1 || st == 2) begin
        exp_err = 1; exp_code = st; m_err = 1; line.delete();
      end else if (st == 3) begin
        m_hold = 1; m_a = ea; m_b = eb; m_opc = eo; line.delete();
      end
    end
    check_eq("cmd_valid", cmd_valid, m_hold);
    check_eq("err_valid", err_valid, exp_err);
    if (exp_err) check_eq("err_code", err_code, exp_code);
    if (err_valid) last_err = err_code;
    if (m_hold) begin
      check_eq("op_a", op_a, m_a);
      check_eq("op_b", op_b, m_b);
      check_eq("opcode", opcode, m_opc);
    end
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; cmd_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hold = 0; m_err = 0; line.delete();
    check_eq("rst_op_a", op_a, 0);
    check_eq("rst_op_b", op_b, 0);
    check_eq("rst_opcode", opcode, 'hFF);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_err_valid", err_valid, 0);
    check_eq("rst_err_code", err_code, 0);
  endtask

  task automatic expect_cmd(input string tag, input int a, input int b, input int opc);
    check_eq({tag, "_valid"}, cmd_valid, 1);
    check_eq({tag, "_op_a"}, op_a, a);
    check_eq({tag, "_op_b"}, op_b, b);
    check_eq({tag, "_opcode"}, opcode, opc);
  endtask

  task automatic push_operand(inout byte unsigned q[$]);
    string dec_set = "0123456789";
    string hex_set = "0123456789abcdef";
    int nd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : $urandom_range(1, 3);
    bit hx = 0;
`ifdef PARSE_HEX_EN
    hx = ($urandom_range(0, 4) == 0);
    if (hx) q.push_back("$");
`endif
    for (int i = 0; i < nd; i++) begin
      if (hx) q.push_back(hex_set[$urandom_range(0, 15)]);
      else    q.push_back(dec_set[$urandom_range(0, 9)]);
      if ($urandom_range(0, 7) == 0) q.push_back(" ");
    end
  endtask

  initial begin
    string ops  = "+-AOXN>/";
    string pool = "0123456789+-AOXN>/ =Q$abcdefz\015";
    byte unsigned q[$];

    m_hold = 0; m_err = 0; last_err = 0;
    do_reset();

    send_str("12+5\015", 1'b1);
    expect_cmd("add", 12, 5, 'h20);
    step(1'b0, 8'h00, 1'b1);

    send_str("300X7=", 1'b0);
    expect_cmd("wrap", 44, 7, 'h26);
    step(1'b0, 8'h00, 1'b1);

    last_err = 0;
    send_str("1234+1\015", 1'b1);
    check_eq("too_long_code", last_err, 2);
    send_str("9/2\015", 1'b0);
    expect_cmd("div", 9, 2, 'h02);
    step(1'b0, 8'h00, 1'b1);

    send_str("4 - 3\015", 1'b0);
    expect_cmd("spaces", 4, 3, 'h22);
    step(1'b0, 8'h00, 1'b1);
    last_err = 0;
    send_str("4Q3\015", 1'b1);
    check_eq("bad_char_code", last_err, 1);

    send_str("1+1\015", 1'b0);
    last_err = 0;
    step(1'b1, "7", 1'b0);
    check_eq("overrun_code", last_err, 3);
    expect_cmd("held", 1, 1, 'h20);
    step(1'b0, 8'h00, 1'b1);
    check_eq("accept_clears", cmd_valid, 0);
    send_str("2N3\015", 1'b0);
    expect_cmd("nand", 2, 3, 'h27);
    step(1'b0, 8'h00, 1'b1);

    send_str("56+", 1'b1);
    do_reset();
    send_str("8>1\015", 1'b0);
    expect_cmd("after_rst", 8, 1, 'h03);
    step(1'b0, 8'h00, 1'b1);

`ifdef PARSE_HEX_EN
    send_str("$ff-$1\015", 1'b0);
    expect_cmd("hex", 255, 1, 'h22);
    step(1'b0, 8'h00, 1'b1);
`else
    last_err = 0;
    step(1'b1, "$", 1'b1);
    check_eq("dollar_code", last_err, 1);
    step(1'b1, 8'd13, 1'b1);
`endif

    for (int ln = 0; ln < 400; ln++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      q.delete();
      if ($urandom_range(0, 9) < 7) begin
        push_operand(q);
        if ($urandom_range(0, 3) == 0) q.push_back(" ");
        q.push_back(ops[$urandom_range(0, 7)]);
        push_operand(q);
        q.push_back(($urandom_range(0, 1) == 0) ? 8'd13 : "=");
      end else begin
        int nb = $urandom_range(1, 6);
        for (int i = 0; i < nb; i++) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
        q.push_back(8'd13);
      end
      foreach (q[i]) begin
        step(1'b1, q[i], $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) step(1'b0, 8'h00, $urandom_range(0, 1) == 1);
      end
      for (int k = $urandom_range(0, 3); k > 0; k--) step(1'b0, 8'h00, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
